// File: rtl/nap_pkg.sv
// Shared definitions for the nap/alarm sequencer: state encoding and width helpers.
package nap_pkg;

  typedef enum logic [2:0] {
    S_AUTO_SET   = 3'd0,
    S_SLEEP      = 3'd1,
    S_ALARM      = 3'd2,
    S_CANCEL     = 3'd3,
    S_START      = 3'd4,
    S_MANUAL_SET = 3'd5,
    S_SNOOZE     = 3'd6
  } napState_e;

  // Bits needed to count 0..snoozeMax inclusive.
  function automatic int snWidth(input int snoozeMax);
    return (snoozeMax < 1) ? 1 : $clog2(snoozeMax + 1);
  endfunction

  // Bits needed to hold the larger of the two tick intervals.
  function automatic int cntWidth(input int ticksA, input int ticksB);
    int maxTicks;
    maxTicks = (ticksA > ticksB) ? ticksA : ticksB;
    return (maxTicks < 1) ? 1 : $clog2(maxTicks + 1);
  endfunction

endpackage

// File: rtl/nap_tick_timer.sv
// Tick-strobe interval counter: synchronous clear wins, counts ticks while enabled,
// saturates at all-ones instead of wrapping.
module nap_tick_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nap_sequencer.sv
// Nap/alarm sequencer: START -> AUTO/MANUAL setting -> SLEEP -> ALARM with bounded snooze,
// timed snooze interval and alarm auto-timeout, all paced by a slow tick strobe.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   START      | idle after reset or cancel, init asserted
//   AUTO_SET   | automatic setting datapath running
//   MANUAL_SET | manual setting datapath running
//   SLEEP      | sleep countdown running
//   ALARM      | alarm sounding, waits for key or timeout
//   SNOOZE     | snooze interval, returns to ALARM when expired
//   CANCEL     | single-cycle cancel pulse, then back to START
module nap_sequencer
  import nap_pkg::*;
#(
  parameter int SNOOZE_MAX    = 3,
  parameter int SNOOZE_TICKS  = 300,
  parameter int ALARM_TIMEOUT = 60,
  parameter int CNT_W         = cntWidth(SNOOZE_TICKS, ALARM_TIMEOUT)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             switch,
  input  logic                             complete_setting,
  input  logic                             complete_sleep,
  input  logic                             sharp,
  input  logic                             star,
  output logic                             init,
  output logic                             en_auto_setting,
  output logic                             en_manual_setting,
  output logic                             en_sleep,
  output logic                             en_alarm,
  output logic                             en_snooze,
  output logic                             en_cancel,
  output logic                             timed_out,
  output logic [snWidth(SNOOZE_MAX)-1:0]   snooze_count,
  output logic [2:0]                       state
);

  localparam int SN_W = snWidth(SNOOZE_MAX);

  napState_e        stateQ;
  napState_e        nextState;
  logic             timeoutHit;
  logic             timerClear;
  logic             timerEnable;
  logic [CNT_W-1:0] timerCount;
  logic             canSnooze;

  assign canSnooze   = (snooze_count < SN_W'(SNOOZE_MAX));
  assign timerClear  = (nextState != stateQ);
  assign timerEnable = (stateQ == S_ALARM) || (stateQ == S_SNOOZE);

  nap_tick_timer #(
    .CNT_W (CNT_W)
  ) uTimer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timerClear),
    .enable (timerEnable),
    .tick   (tick),
    .count  (timerCount)
  );

  always_comb begin
    nextState  = S_START;
    timeoutHit = 1'b0;
    case (stateQ)
      S_START:      nextState = switch ? S_MANUAL_SET : S_AUTO_SET;
      S_AUTO_SET: begin
        if (complete_setting) nextState = S_SLEEP;
        else if (switch)      nextState = S_MANUAL_SET;
        else                  nextState = S_AUTO_SET;
      end
      S_MANUAL_SET: begin
        if (complete_setting) nextState = S_SLEEP;
        else if (!switch)     nextState = S_AUTO_SET;
        else                  nextState = S_MANUAL_SET;
      end
      S_SLEEP: begin
        if (sharp)               nextState = S_CANCEL;
        else if (complete_sleep) nextState = S_ALARM;
        else                     nextState = S_SLEEP;
      end
      // Star at the snooze limit falls through so the timeout keeps running.
      S_ALARM: begin
        if (sharp) begin
          nextState = S_CANCEL;
        end else if (star && canSnooze) begin
          nextState = S_SNOOZE;
        end else if (tick && (timerCount == CNT_W'(ALARM_TIMEOUT - 1))) begin
          nextState  = S_CANCEL;
          timeoutHit = 1'b1;
        end else begin
          nextState = S_ALARM;
        end
      end
      S_SNOOZE: begin
        if (sharp)                                                 nextState = S_CANCEL;
        else if (tick && (timerCount == CNT_W'(SNOOZE_TICKS - 1))) nextState = S_ALARM;
        else                                                       nextState = S_SNOOZE;
      end
      S_CANCEL:     nextState = S_START;
      default:      nextState = S_START;
    endcase
  end

  // Outputs are registered from nextState so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ            <= S_START;
      snooze_count      <= '0;
      timed_out         <= 1'b0;
      init              <= 1'b1;
      en_auto_setting   <= 1'b0;
      en_manual_setting <= 1'b0;
      en_sleep          <= 1'b0;
      en_alarm          <= 1'b0;
      en_snooze         <= 1'b0;
      en_cancel         <= 1'b0;
    end else begin
      stateQ            <= nextState;
      timed_out         <= timeoutHit;
      init              <= (nextState == S_START);
      en_auto_setting   <= (nextState == S_AUTO_SET);
      en_manual_setting <= (nextState == S_MANUAL_SET);
      en_sleep          <= (nextState == S_SLEEP);
      en_alarm          <= (nextState == S_ALARM);
      en_snooze         <= (nextState == S_SNOOZE);
      en_cancel         <= (nextState == S_CANCEL);
      if (stateQ == S_CANCEL) begin
        snooze_count <= '0;
      end else if ((stateQ == S_ALARM) && (nextState == S_SNOOZE)) begin
        snooze_count <= snooze_count + SN_W'(1);
      end
    end
  end

  assign state = stateQ;

endmodule

// File: tb/tb_nap_sequencer.sv
// Directed plus randomized bench for nap_sequencer against a tick-counting reference model.
module tb_nap_sequencer;

  localparam int SNOOZE_MAX    = 2;
  localparam int SNOOZE_TICKS  = 4;
  localparam int ALARM_TIMEOUT = 6;
  localparam int CNT_W         = 3;

  // Encodings fixed by the block definition.
  localparam int M_AUTO   = 0;
  localparam int M_SLEEP  = 1;
  localparam int M_ALARM  = 2;
  localparam int M_CANCEL = 3;
  localparam int M_START  = 4;
  localparam int M_MANUAL = 5;
  localparam int M_SNOOZE = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick, switchIn, completeSetting, completeSleep, sharp, star;
  logic       init, enAuto, enManual, enSleep, enAlarm, enSnooze, enCancel, timedOut;
  logic [1:0] snoozeCount;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int mState, mSnooze, mTicks;
  bit mTimedOut;

  always #5 clock = ~clock;

  nap_sequencer #(
    .SNOOZE_MAX    (SNOOZE_MAX),
    .SNOOZE_TICKS  (SNOOZE_TICKS),
    .ALARM_TIMEOUT (ALARM_TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .tick              (tick),
    .switch            (switchIn),
    .complete_setting  (completeSetting),
    .complete_sleep    (completeSleep),
    .sharp             (sharp),
    .star              (star),
    .init              (init),
    .en_auto_setting   (enAuto),
    .en_manual_setting (enManual),
    .en_sleep          (enSleep),
    .en_alarm          (enAlarm),
    .en_snooze         (enSnooze),
    .en_cancel         (enCancel),
    .timed_out         (timedOut),
    .snooze_count      (snoozeCount),
    .state             (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".state"},     32'(state),       32'(mState));
    check({tag, ".init"},      32'(init),        32'(mState == M_START));
    check({tag, ".enAuto"},    32'(enAuto),      32'(mState == M_AUTO));
    check({tag, ".enManual"},  32'(enManual),    32'(mState == M_MANUAL));
    check({tag, ".enSleep"},   32'(enSleep),     32'(mState == M_SLEEP));
    check({tag, ".enAlarm"},   32'(enAlarm),     32'(mState == M_ALARM));
    check({tag, ".enSnooze"},  32'(enSnooze),    32'(mState == M_SNOOZE));
    check({tag, ".enCancel"},  32'(enCancel),    32'(mState == M_CANCEL));
    check({tag, ".timedOut"},  32'(timedOut),    32'(mTimedOut));
    check({tag, ".snoozeCnt"}, 32'(snoozeCount), 32'(mSnooze));
  endtask

  task automatic modelReset();
    mState    = M_START;
    mSnooze   = 0;
    mTicks    = 0;
    mTimedOut = 0;
  endtask

  // mTicks = ticks seen since entering the current state.
  task automatic modelStep();
    int ns;
    ns        = mState;
    mTimedOut = 0;
    case (mState)
      M_START:  ns = switchIn ? M_MANUAL : M_AUTO;
      M_AUTO:   ns = completeSetting ? M_SLEEP : (switchIn ? M_MANUAL : M_AUTO);
      M_MANUAL: ns = completeSetting ? M_SLEEP : (!switchIn ? M_AUTO : M_MANUAL);
      M_SLEEP:  ns = sharp ? M_CANCEL : (completeSleep ? M_ALARM : M_SLEEP);
      M_ALARM: begin
        if (sharp) ns = M_CANCEL;
        else if (star && mSnooze < SNOOZE_MAX) begin
          ns = M_SNOOZE;
          mSnooze++;
        end else if (tick && mTicks + 1 == ALARM_TIMEOUT) begin
          ns = M_CANCEL;
          mTimedOut = 1;
        end
      end
      M_SNOOZE: begin
        if (sharp) ns = M_CANCEL;
        else if (tick && mTicks + 1 == SNOOZE_TICKS) ns = M_ALARM;
      end
      M_CANCEL: begin
        ns = M_START;
        mSnooze = 0;
      end
      default:  ns = M_START;
    endcase
    if (ns != mState) mTicks = 0;
    else if (tick && (mState == M_ALARM || mState == M_SNOOZE)) mTicks++;
    mState = ns;
  endtask

  task automatic cycle(input string tag);
    modelStep();
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  task automatic idleInputs();
    tick = 0; completeSetting = 0; completeSleep = 0; sharp = 0; star = 0;
  endtask

  initial begin
    reset = 1; switchIn = 0;
    idleInputs();
    modelReset();
    #2;
    checkAll("reset");
    @(posedge clock); #1;
    checkAll("resetHeld");
    reset = 0;

    // 1: auto setting into sleep
    cycle("t1.auto");
    completeSetting = 1;
    cycle("t1.sleep");
    completeSetting = 0;

    // 2: back to AUTO via cancel, then manual, then setting done with switch low
    sharp = 1;
    cycle("t2.cancel");
    sharp = 0;
    cycle("t2.start");
    cycle("t2.auto");
    switchIn = 1;
    cycle("t2.manual");
    switchIn = 0; completeSetting = 1;
    cycle("t2.sleep");
    completeSetting = 0;

    // 3: alarm, snooze, four ticks back to alarm
    completeSleep = 1;
    cycle("t3.alarm");
    completeSleep = 0; star = 1;
    cycle("t3.snooze");
    star = 0; tick = 1;
    repeat (SNOOZE_TICKS) cycle("t3.snoozeTick");
    tick = 0;
    check("t3.backInAlarm", 32'(enAlarm), 32'd1);

    // 4: second snooze, then star ignored and the alarm times out
    star = 1;
    cycle("t4.snooze2");
    star = 0; tick = 1;
    repeat (SNOOZE_TICKS) cycle("t4.snoozeTick");
    star = 1;
    repeat (ALARM_TIMEOUT) cycle("t4.alarmTick");
    check("t4.timedOut", 32'(timedOut), 32'd1);
    star = 0; tick = 0;
    cycle("t4.start");
    check("t4.countCleared", 32'(snoozeCount), 32'd0);

    // 5: sharp and star together in ALARM after one snooze
    cycle("t5.auto");
    completeSetting = 1;
    cycle("t5.sleep");
    completeSetting = 0; completeSleep = 1;
    cycle("t5.alarm");
    completeSleep = 0; star = 1;
    cycle("t5.snooze");
    star = 0; tick = 1;
    repeat (SNOOZE_TICKS) cycle("t5.snoozeTick");
    tick = 0; sharp = 1; star = 1;
    cycle("t5.cancel");
    check("t5.countKept", 32'(snoozeCount), 32'd1);
    sharp = 0; star = 0;
    cycle("t5.start");

    // 6: async reset mid-snooze with timer at 2
    cycle("t6.auto");
    completeSetting = 1;
    cycle("t6.sleep");
    completeSetting = 0; completeSleep = 1;
    cycle("t6.alarm");
    completeSleep = 0; star = 1;
    cycle("t6.snooze");
    star = 0; tick = 1;
    repeat (2) cycle("t6.snoozeTick");
    tick = 0;
    check("t6.timerBefore", 32'(dut.uTimer.count), 32'd2);
    #2 reset = 1;
    modelReset();
    #1;
    checkAll("t6.asyncReset");
    check("t6.timerCleared", 32'(dut.uTimer.count), 32'd0);
    reset = 0;

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      tick            = 1'($urandom_range(0, 1));
      completeSetting = ($urandom_range(0, 3) == 0);
      completeSleep   = ($urandom_range(0, 3) == 0);
      sharp           = ($urandom_range(0, 24) == 0);
      star            = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) switchIn = ~switchIn;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        modelReset();
        #2;
        checkAll("rand.reset");
        reset = 0;
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
